// File: rtl/mont_div_pkg.sv
// Shared definitions for the sequential restoring divider that sits beside
// the Montgomery multiplier datapath.
package mont_div_pkg;

  // Controller state encoding, kept as plain constants for compatibility
  // with the older blocks that decode these values directly.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Width of the step counter: it must hold 2*bits-1 (last step index).
  function automatic int cnt_width(input int bits);
    if (bits < 1) begin
      return 1;
    end else begin
      return $clog2(2 * bits);
    end
  endfunction

endpackage

// File: rtl/mont_seq_div.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, a single
// operation in flight. The dividend register shifts left each step and picks
// up the quotient bit in its LSB, so it ends holding the quotient.
module mont_seq_div
  import mont_div_pkg::*;
#(
  parameter int BITS = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [2*BITS-1:0] i_dat_n,
  input  logic [BITS-1:0]   i_dat_d,
  input  logic              i_val,
  output logic              o_rdy,
  output logic [2*BITS-1:0] o_quo,
  output logic [BITS-1:0]   o_rem,
  output logic              o_dz,
  output logic              o_val,
  input  logic              i_rdy
);

  localparam int NW = 2 * BITS;
  localparam int CW = cnt_width(BITS);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [BITS-1:0] div_r;
  logic [BITS-1:0] rem_r;
  logic [NW-1:0]   quo_r;
  logic            rdy_r;
  logic            val_r;
  logic            dz_r;

  logic [BITS:0]   r_sh_s;
  logic [BITS:0]   diff_s;
  logic            ge_s;

  // One restoring step: shift in the dividend MSB, trial-subtract the divisor
  // at BITS+1 bits. Since r' < 2d the difference is non-negative exactly when
  // r' >= d, so its sign bit doubles as the comparator.
  always_comb begin
    r_sh_s = {rem_r, quo_r[NW-1]};
    diff_s = r_sh_s - {1'b0, div_r};
    ge_s   = ~diff_s[BITS];
  end

  // Next-state decode for the IDLE/CALC/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_val) begin
          state_nxt_s = ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (i_rdy) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Controller state, step counter, datapath registers and handshake outputs.
  // A zero divisor spends a single CALC cycle that installs the saturated
  // result (all-ones quotient, dividend low half as remainder).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      div_r   <= {BITS{1'b0}};
      rem_r   <= {BITS{1'b0}};
      quo_r   <= {NW{1'b0}};
      rdy_r   <= 1'b1;
      val_r   <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (i_val) begin
            rdy_r <= 1'b0;
            quo_r <= i_dat_n;
            rem_r <= {BITS{1'b0}};
            div_r <= i_dat_d;
            if (i_dat_d == {BITS{1'b0}}) begin
              dz_r  <= 1'b1;
              cnt_r <= {CW{1'b0}};
            end else begin
              dz_r  <= 1'b0;
              cnt_r <= CW'(NW - 1);
            end
          end
        end
        ST_CALC: begin
          if (dz_r) begin
            quo_r <= {NW{1'b1}};
            rem_r <= quo_r[BITS-1:0];
          end else begin
            quo_r <= {quo_r[NW-2:0], ge_s};
            rem_r <= ge_s ? diff_s[BITS-1:0] : r_sh_s[BITS-1:0];
          end
          if (cnt_r == {CW{1'b0}}) begin
            val_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (i_rdy) begin
            val_r <= 1'b0;
            rdy_r <= 1'b1;
          end
        end
        default: begin
          val_r <= 1'b0;
          rdy_r <= 1'b1;
        end
      endcase
    end
  end

  assign o_rdy = rdy_r;
  assign o_val = val_r;
  assign o_dz  = dz_r;
  assign o_quo = quo_r;
  assign o_rem = rem_r;

endmodule

// File: tb/tb_mont_seq_div.sv
// Self-checking bench for mont_seq_div: directed and random cases on an
// 8-bit instance (latency, backpressure, reset) and random cases on a
// 64-bit instance, all against a plain-arithmetic division model.
module tb_mont_seq_div;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // 8-bit instance
  logic [15:0] n8;
  logic [7:0]  d8;
  logic        v8;
  logic        rdy8_in;
  logic        rdy8;
  logic [15:0] q8;
  logic [7:0]  rm8;
  logic        dz8;
  logic        val8;

  // 64-bit instance
  logic [127:0] n64;
  logic [63:0]  d64;
  logic         v64;
  logic         rdy64_in;
  logic         rdy64;
  logic [127:0] q64;
  logic [63:0]  rm64;
  logic         dz64;
  logic         val64;

  int checks = 0;
  int errors = 0;

  mont_seq_div #(.BITS(8)) u_div8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_dat_n (n8),
    .i_dat_d (d8),
    .i_val   (v8),
    .o_rdy   (rdy8),
    .o_quo   (q8),
    .o_rem   (rm8),
    .o_dz    (dz8),
    .o_val   (val8),
    .i_rdy   (rdy8_in)
  );

  mont_seq_div #(.BITS(64)) u_div64 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_dat_n (n64),
    .i_dat_d (d64),
    .i_val   (v64),
    .o_rdy   (rdy64),
    .o_quo   (q64),
    .o_rem   (rm64),
    .o_dz    (dz64),
    .o_val   (val64),
    .i_rdy   (rdy64_in)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: quotient/remainder by plain division; zero divisor saturates.
  function automatic void ref_div(input logic [127:0] n, input logic [127:0] d, input int bits,
                                  output logic [127:0] q, output logic [127:0] r, output logic dz);
    logic [127:0] qmask;
    logic [127:0] rmask;
    qmask = {128{1'b1}} >> (128 - 2 * bits);
    rmask = {128{1'b1}} >> (128 - bits);
    if (d == 128'd0) begin
      q  = qmask;
      r  = n & rmask;
      dz = 1'b1;
    end else begin
      q  = n / d;
      r  = n % d;
      dz = 1'b0;
    end
  endfunction

  // One 8-bit operation; hold > 0 keeps i_rdy low for that many cycles after o_val.
  task automatic op8(input logic [15:0] n, input logic [7:0] d, input int hold, input string tag);
    logic [127:0] eq;
    logic [127:0] er;
    logic         edz;
    int           w;
    int           lat;
    ref_div(128'(n), 128'(d), 8, eq, er, edz);
    w = 0;
    while (!rdy8 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_rdy_before"}, 128'(rdy8), 128'd1);
    n8 = n;
    d8 = d;
    v8 = 1'b1;
    rdy8_in = (hold == 0);
    @(negedge clk);
    v8 = 1'b0;
    lat = 1;
    check({tag, "_rdy_busy"}, 128'(rdy8), 128'd0);
    while (!val8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), (d == 8'd0) ? 128'd2 : 128'd17);
    check({tag, "_quo"}, 128'(q8), eq);
    check({tag, "_rem"}, 128'(rm8), er);
    check({tag, "_dz"}, 128'(dz8), 128'(edz));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_val"}, 128'(val8), 128'd1);
        check({tag, "_hold_quo"}, 128'(q8), eq);
        check({tag, "_hold_rem"}, 128'(rm8), er);
        check({tag, "_hold_rdy"}, 128'(rdy8), 128'd0);
      end
      rdy8_in = 1'b1;
    end
    @(negedge clk);
    check({tag, "_val_drop"}, 128'(val8), 128'd0);
    check({tag, "_rdy_after"}, 128'(rdy8), 128'd1);
  endtask

  // One 64-bit operation with i_rdy held high.
  task automatic op64(input logic [127:0] n, input logic [63:0] d);
    logic [127:0] eq;
    logic [127:0] er;
    logic         edz;
    logic [191:0] recon;
    int           w;
    int           lat;
    ref_div(n, 128'(d), 64, eq, er, edz);
    w = 0;
    while (!rdy64 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n64 = n;
    d64 = d;
    v64 = 1'b1;
    @(negedge clk);
    v64 = 1'b0;
    lat = 1;
    while (!val64 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("w64_latency", 128'(lat), (d == 64'd0) ? 128'd2 : 128'd129);
    check("w64_quo", q64, eq);
    check("w64_rem", 128'(rm64), er);
    check("w64_dz", 128'(dz64), 128'(edz));
    if (d != 64'd0) begin
      recon = {64'd0, q64} * {128'd0, d64} + {128'd0, rm64};
      check("w64_qd_plus_r", 128'(recon == {64'd0, n}), 128'd1);
      check("w64_r_lt_d", 128'(rm64 < d), 128'd1);
    end
    @(negedge clk);
    check("w64_val_pulse", 128'(val64), 128'd0);
  endtask

  initial begin
    logic [127:0] rn;
    logic [63:0]  rd;
    rst_n    = 1'b0;
    n8       = 16'd0;
    d8       = 8'd0;
    v8       = 1'b0;
    rdy8_in  = 1'b1;
    n64      = 128'd0;
    d64      = 64'd0;
    v64      = 1'b0;
    rdy64_in = 1'b1;

    #12;
    check("reset_rdy", 128'(rdy8), 128'd1);
    check("reset_val", 128'(val8), 128'd0);
    check("reset_quo", 128'(q8), 128'd0);
    check("reset_rem", 128'(rm8), 128'd0);
    check("reset_dz", 128'(dz8), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op8(16'd1000, 8'd7, 0, "d1000_7");
    op8(16'hFFFF, 8'h01, 0, "ffff_01");
    op8(16'hFFFF, 8'hFF, 0, "ffff_ff");
    op8(16'h0005, 8'h09, 0, "small_n");
    op8(16'h1234, 8'h00, 0, "div_zero");
    op8(16'd1000, 8'd7, 5, "backpress");
    for (int i = 0; i < 20; i++) begin
      op8(16'($urandom), (i % 7 == 0) ? 8'd0 : 8'($urandom), 0, "rand8");
    end

    // Reset in the middle of a calculation.
    while (!rdy8) @(negedge clk);
    n8 = 16'd1000;
    d8 = 8'd7;
    v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_quo", 128'(q8), 128'd0);
    check("midrst_rem", 128'(rm8), 128'd0);
    check("midrst_val", 128'(val8), 128'd0);
    check("midrst_dz", 128'(dz8), 128'd0);
    check("midrst_rdy", 128'(rdy8), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op8(16'd100, 8'd10, 0, "post_rst");

    // 64-bit: boundary divisors, then random operands.
    op64({4{32'hDEADBEEF}}, 64'd1);
    op64({4{32'hFFFFFFFF}}, {64{1'b1}});
    op64({4{32'h12345678}}, 64'd0);
    for (int i = 0; i < 280; i++) begin
      rn = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) begin
        rn = 128'($urandom);
      end
      case (i % 40)
        0:       rd = 64'd1;
        1:       rd = {64{1'b1}};
        2:       rd = 64'd0;
        3:       rd = 64'd2;
        default: rd = ($urandom_range(0, 1) == 0) ? 64'($urandom) : {$urandom, $urandom};
      endcase
      op64(rn, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
